// File: rtl/branch_pkg.sv
// Shared types and constants for the branch resolve stage.
// Latency: n/a (package only). Backpressure: n/a.
package branch_pkg;

    typedef enum logic {
        IDLE   = 1'b0,
        SQUASH = 1'b1
    } state_t;

    localparam int SQUASH_CYCLES_DEF = 2;
    localparam int CNT_W             = 3;

endpackage

// File: rtl/squash_counter.sv
// Squash window counter: load, decrement when enabled, flags the last count.
// Latency: 1 cycle load/decrement. Backpressure: decrement gated by i_dec.
module squash_counter
    import branch_pkg::*;
(
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_load,
    input  logic [CNT_W-1:0] i_load_val,
    input  logic             i_dec,
    output logic [CNT_W-1:0] o_count,
    output logic             o_last
);

    logic [CNT_W-1:0] r_count;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= i_load_val;
        end else if (i_dec && (r_count != '0)) begin
            r_count <= r_count - 1'b1;
        end
    end

    // The next decrement takes the counter to zero.
    assign o_last  = (r_count == CNT_W'(1));
    assign o_count = r_count;

endmodule

// File: rtl/branch_resolve_stage.sv
// Resolves BEQ/BNE at end of EX, registers into EX/MEM, redirects fetch, squashes wrong path.
// Latency 1 cycle; i_stall freezes all state, i_flush inserts a bubble.
// Optional BRANCH_STATS_EN adds o_branchCount/o_takenCount.
module branch_resolve_stage
    import branch_pkg::*;
#(
    parameter int SQUASH_CYCLES = SQUASH_CYCLES_DEF
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_stall,
    input  logic        i_flush,
    input  logic        i_exValid,
    input  logic [31:0] i_pcPlus4,
    input  logic [31:0] i_shiftedOffset,
    input  logic        i_aluZero,
    input  logic        i_isBeq,
    input  logic        i_isBne,
    output logic        o_memValid,
    output logic [31:0] o_branchTarget,
    output logic        o_branchTaken,
    output logic        o_redirect,
    output logic        o_squash
`ifdef BRANCH_STATS_EN
    ,
    output logic [31:0] o_branchCount,
    output logic [31:0] o_takenCount
`endif
);

    localparam logic             SQ_EN   = (SQUASH_CYCLES > 0);
    localparam logic [CNT_W-1:0] SQ_LOAD = CNT_W'(SQUASH_CYCLES);

    state_t           r_state;
    logic             r_squash;
    logic             r_memValid;
    logic             r_branchTaken;
    logic [31:0]      r_branchTarget;

    logic [31:0]      w_target;
    logic             w_taken;
    logic             w_killed;
    logic             w_capture;
    logic             w_new_taken;
    logic             w_load;
    logic             w_dec;
    logic [CNT_W-1:0] w_count;
    logic             w_last;

    assign w_target    = i_pcPlus4 + i_shiftedOffset;
    assign w_taken     = i_exValid & ((i_isBeq & i_aluZero) | (~i_isBeq & i_isBne & ~i_aluZero));
    assign w_killed    = (r_state == SQUASH);
    assign w_capture   = ~i_rst & ~i_flush & ~i_stall;
    assign w_new_taken = w_capture & w_taken & ~w_killed;
    assign w_load      = w_new_taken & SQ_EN;
    assign w_dec       = ~i_stall & w_killed;

    squash_counter u_squash_counter (
        .i_clk      (i_clk),
        .i_rst      (i_rst),
        .i_load     (w_load),
        .i_load_val (SQ_LOAD),
        .i_dec      (w_dec),
        .o_count    (w_count),
        .o_last     (w_last)
    );

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_memValid     <= 1'b0;
            r_branchTaken  <= 1'b0;
            r_branchTarget <= '0;
        end else if (i_flush) begin
            r_memValid     <= 1'b0;
            r_branchTaken  <= 1'b0;
        end else if (!i_stall) begin
            r_memValid     <= i_exValid & ~w_killed;
            r_branchTaken  <= w_taken & ~w_killed;
            r_branchTarget <= w_target;
        end
    end

    // Wrong-path branches inside the window never reload the counter.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state  <= IDLE;
            r_squash <= 1'b0;
        end else if (!i_stall) begin
            case (r_state)
                IDLE: begin
                    if (w_load) begin
                        r_state  <= SQUASH;
                        r_squash <= 1'b1;
                    end
                end
                SQUASH: begin
                    if (w_last || (w_count == '0)) begin
                        r_state  <= IDLE;
                        r_squash <= 1'b0;
                    end
                end
                default: begin
                    r_state  <= IDLE;
                    r_squash <= 1'b0;
                end
            endcase
        end
    end

    assign o_memValid     = r_memValid;
    assign o_branchTaken  = r_branchTaken;
    assign o_branchTarget = r_branchTarget;
    assign o_redirect     = r_memValid & r_branchTaken;
    assign o_squash       = r_squash;

`ifdef BRANCH_STATS_EN
    logic [31:0] r_branchCount;
    logic [31:0] r_takenCount;
    logic        w_new_branch;

    assign w_new_branch = w_capture & i_exValid & (i_isBeq | i_isBne) & ~w_killed;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_branchCount <= '0;
            r_takenCount  <= '0;
        end else begin
            if (w_new_branch) r_branchCount <= r_branchCount + 32'd1;
            if (w_new_taken)  r_takenCount  <= r_takenCount + 32'd1;
        end
    end

    assign o_branchCount = r_branchCount;
    assign o_takenCount  = r_takenCount;
`endif

endmodule

// File: doc/branch_resolve_stage.md
# branch_resolve_stage

Resolves conditional branches at the end of the EX stage. It consumes the word-aligned offset produced by the EX shift-left-by-2 unit, adds it to PC+4 to form the branch target, and evaluates BEQ/BNE against the ALU zero flag. It registers the result into the EX/MEM boundary, pulses a fetch redirect, and holds a squash window that kills wrong-path instructions behind a taken branch.

## Interface
- SQUASH_CYCLES, 2, number of cycles younger instructions are killed after a taken branch (0 to 7)
- clk  in  1  system clock, all state updates on the rising edge
- rst  in  1  synchronous, active-high reset
- stall  in  1  hazard-unit hold; all state frozen
- flush  in  1  external flush; next capture is a bubble
- exValid  in  1  EX-stage instruction is valid
- pcPlus4  in  32  PC+4 of the EX instruction
- shiftedOffset  in  32  sign-extended immediate shifted left by 2, from the EX shifter
- aluZero  in  1  ALU zero flag of the EX instruction
- isBeq  in  1  EX instruction is BEQ
- isBne  in  1  EX instruction is BNE
- memValid  out  1  registered valid for the EX/MEM slot
- branchTarget  out  32  registered pcPlus4 + shiftedOffset
- branchTaken  out  1  registered taken decision
- redirect  out  1  one-cycle fetch redirect for a taken branch
- squash  out  1  kill signal to IF/ID/EX while the squash window is open

## Operation
- Target: pcPlus4 + shiftedOffset, 32-bit, modulo 2^32 (wraps silently, no overflow flag).
- Condition: takenComb = exValid & ((isBeq & aluZero) | (~isBeq & isBne & ~aluZero)). BEQ takes priority if both decode lines are high.
- Capture, evaluated by priority at each edge:
  - rst: clears all registers, state IDLE.
  - flush: memValid=0 and branchTaken=0; branchTarget is don't-care and is held.
  - stall: every register and the counter hold.
  - otherwise: memValid = exValid & ~killed, branchTaken = takenComb & ~killed, branchTarget = target. killed = (state==SQUASH).
- FSM states IDLE and SQUASH:
  - IDLE→SQUASH when a non-killed taken branch is captured and SQUASH_CYCLES>0. The counter loads SQUASH_CYCLES.
  - In SQUASH, the counter decrements on each non-stalled edge. It returns to IDLE on the edge where the counter reaches 0.
  - A taken branch arriving during SQUASH is wrong-path. It is killed and does not reload the counter.
  - flush does not alter the FSM or the counter.
- redirect = memValid & branchTaken (combinational from registers). It is high exactly one cycle per branch because of the squash and IDLE gating. While stalled, it stays high until the stall releases.
- squash = (state==SQUASH), registered.
- With SQUASH_CYCLES=0, the FSM stays in IDLE and only redirect is produced.

## Timing
- Reset values: memValid=0, branchTarget=0, branchTaken=0, redirect=0, squash=0, state IDLE, counter 0.
- Latency is 1 cycle. Inputs sampled at edge N appear on the outputs in cycle N+1.
- For a taken branch sampled at edge N:
  - redirect is high in cycle N+1.
  - squash is high in cycles N+1 through N+SQUASH_CYCLES, plus any stall cycles.
- Simultaneous events:
  - rst beats flush, and flush beats stall.
  - A taken branch together with flush is dropped, with no redirect and no squash.
- Reset mid-squash ends the window immediately. squash is 0 the cycle after rst.

## Configuration
- BRANCH_STATS_EN defined: adds two outputs.
  - branchCount[31:0] increments on each captured non-killed BEQ/BNE.
  - takenCount[31:0] increments on each captured taken branch.
  - Both reset to 0, wrap at 2^32, and hold during stall and flush.
- BRANCH_STATS_EN undefined: both ports and counters are absent, and behaviour is otherwise identical.

## Structure
- Shared package branch_pkg holds:
  - the state enum (IDLE, SQUASH)
  - the SQUASH_CYCLES default
  - the counter width constant, 3 bits
- Sub-module squash_counter: load, decrement-when-enabled, and zero detect. It is instantiated once.
- The target adder and condition logic stay inline.

## Test plan
- BEQ taken: pcPlus4=0x00400010, shiftedOffset=0x00000020, aluZero=1 → next cycle branchTarget=0x00400030, branchTaken=1, redirect=1 for 1 cycle, squash=1 for 2 cycles.
- BNE not taken: aluZero=1, isBne=1 → memValid=1, branchTaken=0, redirect=0, squash=0.
- Wrap and negative offset:
  - pcPlus4=0xFFFFFFFC, offset=0x00000008 → target 0x00000004.
  - pcPlus4=0x00400010, offset=0xFFFFFFF0 → target 0x00400000.
- Taken branch on the cycle after a taken branch → captured with memValid=0 and branchTaken=0, no second redirect, squash still ends after 2 cycles.
- Stall for 3 cycles during squash → squash is held for 5 cycles total, and the outputs are frozen. Asserting flush with a taken branch → bubble, no redirect.
- rst asserted mid-squash → the following cycle has all outputs 0 and state IDLE. With BRANCH_STATS_EN, 4 branches with 3 taken → branchCount=4, takenCount=3.
